// File: rtl/icache_pf_pkg.sv
// ============================================================================
// Module      : icache_pf_pkg
// Description : Shared types and widths for the icache prefetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pf_pkg;

    localparam int PF_ADDR_W = 32;
    localparam int PF_SIZE_W = 8;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_ISSUE = 2'd1,
        PF_DRAIN = 2'd2
    } pf_state_e;

    // Clears the byte-offset bits of an address for a power-of-two line size.
    function automatic logic [PF_ADDR_W-1:0] pf_line_align(
        input logic [PF_ADDR_W-1:0] addr,
        input int unsigned          line_bytes
    );
        return addr & ~(PF_ADDR_W'(line_bytes) - PF_ADDR_W'(1));
    endfunction

endpackage : icache_pf_pkg

`default_nettype wire

// File: rtl/icache_pf_sequencer.sv
// ============================================================================
// Module      : icache_pf_sequencer
// Description : Splits a prefetch command into line requests and tracks
//               outstanding refills until every issued line has returned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_pf_sequencer
    import icache_pf_pkg::*;
#(
    parameter int LINE_BYTES      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pf_req_i,
    input  logic [PF_ADDR_W-1:0] pf_addr_i,
    input  logic [PF_SIZE_W-1:0] pf_size_i,
    output logic                 pf_ack_o,
    output logic                 pf_done_o,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 pref_req_o,
    output logic [PF_ADDR_W-1:0] pref_addr_o,
    input  logic                 pref_gnt_i,
    input  logic                 pref_rvalid_i
);

    localparam int                   C_OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [C_OUT_W-1:0]   C_MAX_OUT  = C_OUT_W'(MAX_OUTSTANDING);
    localparam logic [C_OUT_W-1:0]   C_OUT_ONE  = C_OUT_W'(1);
    localparam logic [PF_ADDR_W-1:0] C_LINE_INC = PF_ADDR_W'(LINE_BYTES);
    localparam logic [PF_SIZE_W-1:0] C_SIZE_ONE = PF_SIZE_W'(1);

    pf_state_e              r_state;
    logic [PF_ADDR_W-1:0]   r_addr;
    logic [PF_SIZE_W-1:0]   r_remaining;
    logic [C_OUT_W-1:0]     r_outstanding;
    logic                   r_ack;
    logic                   r_done;

    logic                   w_pref_req;
    logic                   w_grant;
    logic [C_OUT_W-1:0]     w_out_next;

    always_comb begin
        w_pref_req = (r_state == PF_ISSUE) && (r_remaining != '0) &&
                     (r_outstanding < C_MAX_OUT) && !abort_i;
        w_grant    = w_pref_req && pref_gnt_i;

        // A grant and a return in the same cycle cancel; returns with
        // nothing outstanding are dropped so the counter cannot underflow.
        w_out_next = r_outstanding;
        if (w_grant && !pref_rvalid_i) begin
            w_out_next = r_outstanding + C_OUT_ONE;
        end else if (!w_grant && pref_rvalid_i && (r_outstanding != '0)) begin
            w_out_next = r_outstanding - C_OUT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= PF_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_ack         <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_ack         <= 1'b0;
            r_done        <= 1'b0;

            case (r_state)
                PF_IDLE: begin
                    if (pf_req_i) begin
                        r_addr      <= pf_line_align(pf_addr_i, LINE_BYTES);
                        r_remaining <= pf_size_i;
                        r_ack       <= 1'b1;
                        r_state     <= (pf_size_i != '0) ? PF_ISSUE : PF_DRAIN;
                    end
                end

                PF_ISSUE: begin
                    if (abort_i) begin
                        r_remaining <= '0;
                        r_state     <= PF_DRAIN;
                    end else if (w_grant) begin
                        r_addr      <= r_addr + C_LINE_INC;
                        r_remaining <= r_remaining - C_SIZE_ONE;
                        if (r_remaining == C_SIZE_ONE) begin
                            r_state <= PF_DRAIN;
                        end
                    end
                end

                PF_DRAIN: begin
                    // Looking at the next count lets done trail the final
                    // return by a single cycle.
                    if (w_out_next == '0) begin
                        r_done  <= 1'b1;
                        r_state <= PF_IDLE;
                    end
                end

                default: begin
                    r_state <= PF_IDLE;
                end
            endcase
        end
    end

    assign pf_ack_o    = r_ack;
    assign pf_done_o   = r_done;
    assign busy_o      = (r_state != PF_IDLE);
    assign pref_req_o  = w_pref_req;
    assign pref_addr_o = r_addr;

endmodule : icache_pf_sequencer

`default_nettype wire

// File: tb/tb_icache_pf_sequencer.sv
// ============================================================================
// Module      : tb_icache_pf_sequencer
// Description : Randomized self-checking bench with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_pf_sequencer;

    localparam int LINE_BYTES      = 16;
    localparam int MAX_OUTSTANDING = 4;
    localparam logic [31:0] C_LMASK = ~(32'(LINE_BYTES) - 32'd1);

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        pf_req_i;
    logic [31:0] pf_addr_i;
    logic [7:0]  pf_size_i;
    logic        pf_ack_o;
    logic        pf_done_o;
    logic        abort_i;
    logic        busy_o;
    logic        pref_req_o;
    logic [31:0] pref_addr_o;
    logic        pref_gnt_i;
    logic        pref_rvalid_i;

    always #5 clk = ~clk;

    icache_pf_sequencer #(
        .LINE_BYTES      (LINE_BYTES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .pf_req_i      (pf_req_i),
        .pf_addr_i     (pf_addr_i),
        .pf_size_i     (pf_size_i),
        .pf_ack_o      (pf_ack_o),
        .pf_done_o     (pf_done_o),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .pref_req_o    (pref_req_o),
        .pref_addr_o   (pref_addr_o),
        .pref_gnt_i    (pref_gnt_i),
        .pref_rvalid_i (pref_rvalid_i)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int grants;
    logic [31:0] gaddr[$];
    int unsigned rq[$];

    // stimulus knobs
    bit          s_req, s_gnt, s_gnt_rand, s_abort, s_abort_rand, s_hold, s_spur;
    logic [31:0] s_addr;
    logic [7:0]  s_size;
    int          s_lat;

    // model: command progress expressed as counts of lines and returns
    bit          m_active;     // a command has been accepted and not completed
    bit          m_issuing;    // lines may still be handed out
    int          m_left;
    int          m_out;
    logic [31:0] m_addr;
    bit          m_ack, m_done;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] gaddr_at(input int i);
        return (gaddr.size() > i) ? gaddr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_active = 0; m_issuing = 0; m_left = 0; m_out = 0;
        m_addr = '0; m_ack = 0; m_done = 0;
    endtask

    task automatic step();
        bit rv, exp_req, mg;
        int due, nout;
        @(negedge clk);
        pf_req_i   = s_req;
        pf_addr_i  = s_addr;
        pf_size_i  = s_size;
        abort_i    = s_abort || (s_abort_rand && ($urandom_range(0, 29) == 0));
        pref_gnt_i = s_gnt_rand ? ($urandom_range(0, 99) < 70) : s_gnt;
        rv = 0;
        if (!s_hold && rq.size() > 0 && rq[0] <= cyc) rv = 1;
        else if (s_spur && rq.size() == 0 && m_out == 0 && $urandom_range(0, 19) == 0) rv = 1;
        pref_rvalid_i = rv;
        #1;
        exp_req = m_issuing && (m_left > 0) && (m_out < MAX_OUTSTANDING) && !abort_i;
        check_value("ack",  pf_ack_o,    m_ack);
        check_value("done", pf_done_o,   m_done);
        check_value("busy", busy_o,      m_active);
        check_value("req",  pref_req_o,  exp_req);
        check_value("addr", pref_addr_o, m_addr);

        // refill engine answers whatever the DUT actually granted, in order
        if (pref_req_o && pref_gnt_i) begin
            grants++;
            gaddr.push_back(pref_addr_o);
            due = cyc + ((s_lat > 0) ? s_lat : int'($urandom_range(1, 4)));
            if (rq.size() > 0 && int'(rq[$]) > due) due = rq[$];
            rq.push_back(due);
        end
        if (rv && rq.size() > 0) void'(rq.pop_front());

        @(posedge clk);
        mg   = exp_req && pref_gnt_i;
        nout = m_out;
        if (mg && !rv) nout = m_out + 1;
        else if (!mg && rv && m_out > 0) nout = m_out - 1;

        m_ack  = !m_active && pf_req_i;
        m_done = m_active && !m_issuing && (nout == 0);
        if (!m_active) begin
            if (pf_req_i) begin
                m_active  = 1;
                m_issuing = (pf_size_i != 0);
                m_left    = pf_size_i;
                m_addr    = pf_addr_i & C_LMASK;
            end
        end else if (m_issuing) begin
            if (abort_i) begin
                m_left = 0; m_issuing = 0;
            end else if (mg) begin
                m_addr = m_addr + 32'(LINE_BYTES);
                m_left--;
                if (m_left == 0) m_issuing = 0;
            end
        end else if (nout == 0) begin
            m_active = 0;
        end
        m_out = nout;
        cyc++;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (m_active && n < limit) begin
            step();
            n++;
        end
        check_value("drain_bound", 32'(n < limit), 32'd1);
    endtask

    task automatic launch(input logic [31:0] a, input logic [7:0] sz);
        s_addr = a; s_size = sz; s_req = 1;
        step();
        s_req = 0;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [7:0] sz);
        launch(a, sz);
        wait_idle(500);
        step();
    endtask

    task automatic clear_log();
        grants = 0;
        gaddr.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 0; pf_req_i = 0; abort_i = 0; pref_rvalid_i = 0; pref_gnt_i = 0;
        #1;
        check_value("rst_ack",  pf_ack_o,    0);
        check_value("rst_done", pf_done_o,   0);
        check_value("rst_busy", busy_o,      0);
        check_value("rst_req",  pref_req_o,  0);
        check_value("rst_addr", pref_addr_o, 0);
        model_reset();
        rq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 0; pf_req_i = 0; pf_addr_i = '0; pf_size_i = '0;
        abort_i = 0; pref_gnt_i = 0; pref_rvalid_i = 0;
        s_req = 0; s_gnt = 1; s_gnt_rand = 0; s_abort = 0; s_abort_rand = 0;
        s_hold = 0; s_spur = 0; s_addr = '0; s_size = '0; s_lat = 2;
        model_reset();
        clear_log();
        repeat (2) @(posedge clk);
        do_reset();

        // basic three-line command, grant tied high, returns 2 cycles later
        clear_log(); s_gnt = 1; s_lat = 2;
        run_cmd(32'h1000_0004, 8'd3);
        check_value("basic_grants", grants, 3);
        check_value("basic_a0", gaddr_at(0), 32'h1000_0000);
        check_value("basic_a1", gaddr_at(1), 32'h1000_0010);
        check_value("basic_a2", gaddr_at(2), 32'h1000_0020);

        // outstanding limit with returns withheld
        clear_log(); s_hold = 1; s_lat = 1;
        launch(32'h2000_0000, 8'd6);
        repeat (8) step();
        check_value("limit_grants", grants, 4);
        s_hold = 0; step(); s_hold = 1;
        repeat (5) step();
        check_value("limit_one_more", grants, 5);
        s_hold = 0;
        wait_idle(200);
        check_value("limit_total", grants, 6);

        // zero-size command
        clear_log();
        run_cmd(32'h3000_0008, 8'd0);
        check_value("zero_grants", grants, 0);

        // abort after two grants
        clear_log(); s_lat = 0;
        launch(32'h4000_0000, 8'd8);
        step(); step();
        s_abort = 1; step(); s_abort = 0;
        wait_idle(200);
        check_value("abort_grants", grants, 2);

        // address wrap with a return coincident with the second grant
        clear_log(); s_lat = 1;
        run_cmd(32'hFFFF_FFF0, 8'd2);
        check_value("wrap_a0", gaddr_at(0), 32'hFFFF_FFF0);
        check_value("wrap_a1", gaddr_at(1), 32'h0000_0000);

        // reset while draining two outstanding lines, then a fresh command
        clear_log(); s_hold = 1; s_lat = 2;
        launch(32'h5000_0000, 8'd2);
        step(); step(); step();
        do_reset();
        s_hold = 0;
        clear_log();
        run_cmd(32'h1000_0004, 8'd3);
        check_value("fresh_grants", grants, 3);
        check_value("fresh_a0", gaddr_at(0), 32'h1000_0000);

        // randomized commands, grants, aborts, latencies and stray returns
        s_gnt_rand = 1; s_abort_rand = 1; s_spur = 1; s_lat = 0;
        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom, 8'($urandom_range(0, 10)));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_icache_pf_sequencer

`default_nettype wire
